// File: rtl/snake_pkg.sv
// Shared constants and types for the snake renderer: grid geometry, directions,
// start position and palette.
package snake_pkg;
   localparam int GRID_W     = 80;
   localparam int GRID_H     = 60;
   localparam int CELL_SHIFT = 3;
   localparam int XW         = 7;
   localparam int YW         = 6;

   typedef enum logic [1:0] {
      DIR_UP    = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_LEFT  = 2'b11
   } dir_e;

   localparam logic [XW-1:0] START_X   = 7'd40;
   localparam logic [YW-1:0] START_Y   = 6'd30;
   localparam int            START_LEN = 4;

   localparam logic [11:0] BG_COL     = 12'h040;
   localparam logic [11:0] BODY_COL   = 12'hFF0;
   localparam logic [11:0] HEAD_COL   = 12'hF80;
   localparam logic [11:0] TARGET_COL = 12'hF00;
   localparam logic [11:0] DEAD_COL   = 12'hFFF;

   // Up/down and left/right differ only in the top bit of the encoding.
   function automatic logic is_opposite(input dir_e a, input dir_e b);
      return (a ^ b) == 2'b10;
   endfunction
endpackage

// File: rtl/snake_step.sv
// Next-head calculator: one cell in the given direction with toroidal wrap.
module snake_step
   import snake_pkg::*;
#(
   parameter int GRID_W = snake_pkg::GRID_W,
   parameter int GRID_H = snake_pkg::GRID_H
) (
   input  logic [XW-1:0] head_x_i,
   input  logic [YW-1:0] head_y_i,
   input  dir_e          dir_i,
   output logic [XW-1:0] next_x_o,
   output logic [YW-1:0] next_y_o
);
   localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

   always_comb begin
      next_x_o = head_x_i;
      next_y_o = head_y_i;
      case (dir_i)
         DIR_UP:    next_y_o = (head_y_i == '0)    ? Y_MAX : head_y_i - 1'b1;
         DIR_DOWN:  next_y_o = (head_y_i == Y_MAX) ? '0    : head_y_i + 1'b1;
         DIR_RIGHT: next_x_o = (head_x_i == X_MAX) ? '0    : head_x_i + 1'b1;
         DIR_LEFT:  next_x_o = (head_x_i == '0)    ? X_MAX : head_x_i - 1'b1;
         default: ;
      endcase
   end
endmodule

// File: rtl/snake_renderer.sv
// Snake game state (segment shift register, direction, growth, collision) and a
// one-cycle-latency pixel colour generator keyed on the VGA pixel address.
module snake_renderer
   import snake_pkg::*;
#(
   parameter int MAX_LEN = 16,
   parameter int GRID_W  = snake_pkg::GRID_W,
   parameter int GRID_H  = snake_pkg::GRID_H
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [18:0]   addr_i,
   input  logic          move_tick_i,
   input  logic [1:0]    dir_i,
   input  logic          grow_i,
   input  logic [XW-1:0] target_x_i,
   input  logic [YW-1:0] target_y_i,
   output logic [11:0]   colour_o,
   output logic [XW-1:0] head_x_o,
   output logic [YW-1:0] head_y_o,
   output logic [5:0]    length_o,
   output logic          dead_o
);
   logic [XW-1:0] seg_x_q [MAX_LEN];
   logic [YW-1:0] seg_y_q [MAX_LEN];
   logic [5:0]    length_q, length_d;
   dir_e          dir_q, dir_eff;
   logic          dead_q, grow_pend_q;
   logic [11:0]   colour_q, colour_d;

   logic [XW-1:0] next_x, cx;
   logic [YW-1:0] next_y, cy;
   logic [MAX_LEN-1:0] collide_vec, body_vec;
   logic          collide, body_hit, head_hit, target_hit, advance, grow_eff;
   logic          unused_addr_bits;

   assign cx = addr_i[18:12];
   assign cy = addr_i[8:3];
   assign unused_addr_bits = ^{addr_i[11:9], addr_i[2:0]};

   assign dir_eff = is_opposite(dir_e'(dir_i), dir_q) ? dir_q : dir_e'(dir_i);

   snake_step #(.GRID_W(GRID_W), .GRID_H(GRID_H)) u_step (
      .head_x_i (seg_x_q[0]),
      .head_y_i (seg_y_q[0]),
      .dir_i    (dir_eff),
      .next_x_o (next_x),
      .next_y_o (next_y)
   );

   // The tail cell (index LENGTH-1) is excluded from collision because it vacates on this move.
   for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_cmp
      assign collide_vec[gi] = (7'(gi + 2) <= {1'b0, length_q}) &&
                               (seg_x_q[gi] == next_x) && (seg_y_q[gi] == next_y);
      if (gi == 0) begin : g_head
         assign body_vec[gi] = 1'b0;
      end else begin : g_body
         assign body_vec[gi] = (7'(gi) < {1'b0, length_q}) &&
                               (seg_x_q[gi] == cx) && (seg_y_q[gi] == cy);
      end
   end

   assign collide    = |collide_vec;
   assign body_hit   = |body_vec;
   assign head_hit   = (seg_x_q[0] == cx) && (seg_y_q[0] == cy);
   assign target_hit = (target_x_i == cx) && (target_y_i == cy);
   assign advance    = move_tick_i && !dead_q && !collide;
   assign grow_eff   = grow_pend_q || grow_i;

   always_comb begin
      length_d = length_q;
      if (grow_eff && (length_q < 6'(MAX_LEN)))
         length_d = length_q + 1'b1;
   end

   always_comb begin
      colour_d = BG_COL;
      if (head_hit)        colour_d = dead_q ? DEAD_COL : HEAD_COL;
      else if (body_hit)   colour_d = BODY_COL;
      else if (target_hit) colour_d = TARGET_COL;
   end

   for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
      localparam logic [XW-1:0] RST_X = (gi < START_LEN) ? XW'(START_X - gi) : '0;
      localparam logic [YW-1:0] RST_Y = (gi < START_LEN) ? START_Y : '0;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            seg_x_q[gi] <= RST_X;
            seg_y_q[gi] <= RST_Y;
         end else if (advance) begin
            if (gi == 0) begin
               seg_x_q[gi] <= next_x;
               seg_y_q[gi] <= next_y;
            end else begin
               seg_x_q[gi] <= seg_x_q[gi-1];
               seg_y_q[gi] <= seg_y_q[gi-1];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         length_q    <= 6'(START_LEN);
         dir_q       <= DIR_RIGHT;
         dead_q      <= 1'b0;
         grow_pend_q <= 1'b0;
         colour_q    <= '0;
      end else begin
         colour_q <= colour_d;
         if (!dead_q) begin
            if (move_tick_i && collide) begin
               dead_q <= 1'b1;
            end else if (move_tick_i) begin
               length_q    <= length_d;
               dir_q       <= dir_eff;
               grow_pend_q <= 1'b0;
            end else if (grow_i) begin
               grow_pend_q <= 1'b1;
            end
         end
      end
   end

   assign colour_o = colour_q;
   assign head_x_o = seg_x_q[0];
   assign head_y_o = seg_y_q[0];
   assign length_o = length_q;
   assign dead_o   = dead_q;
endmodule

// File: tb/tb_snake_renderer.sv
// Directed bench for snake_renderer: expected values queued at stimulus time,
// popped and checked when the DUT output is sampled.
module tb_snake_renderer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [18:0] addr = '0;
   logic        move_tick = 1'b0;
   logic [1:0]  dir = 2'b01;
   logic        grow = 1'b0;
   logic [6:0]  target_x = 7'd70;
   logic [5:0]  target_y = 6'd50;
   logic [11:0] colour;
   logic [6:0]  head_x;
   logic [5:0]  head_y;
   logic [5:0]  length;
   logic        dead;

   int          test_cnt = 0;
   int          fail_cnt = 0;
   logic [31:0] exp_q [$];
   string       tag_q [$];

   always #20 clk = ~clk;

   snake_renderer #(.MAX_LEN(16)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .addr_i      (addr),
      .move_tick_i (move_tick),
      .dir_i       (dir),
      .grow_i      (grow),
      .target_x_i  (target_x),
      .target_y_i  (target_y),
      .colour_o    (colour),
      .head_x_o    (head_x),
      .head_y_o    (head_y),
      .length_o    (length),
      .dead_o      (dead)
   );

   task automatic expect_val(input string tag, input logic [31:0] val);
      exp_q.push_back(val);
      tag_q.push_back(tag);
   endtask

   task automatic check_pop(input logic [31:0] obs);
      logic [31:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      test_cnt++;
      assert (obs === e) else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
      $display("[TB] check %s observed=%0h expected=%0h", t, obs, e);
   endtask

   task automatic pixel(input int x, input int y, input logic [11:0] col, input string tag);
      @(negedge clk);
      addr = {10'(x), 9'(y)};
      expect_val(tag, 32'(col));
      @(negedge clk);
      check_pop(32'(colour));
   endtask

   task automatic tick(input logic [1:0] d, input logic g);
      @(negedge clk);
      move_tick = 1'b1;
      dir = d;
      grow = g;
      @(negedge clk);
      move_tick = 1'b0;
      grow = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #5;
      expect_val("rst_colour", 32'h0);
      check_pop(32'(colour));
      expect_val("rst_length", 32'd4);
      check_pop(32'(length));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset state and basic rendering
      do_reset();
      expect_val("rst_dead", 32'd0);     check_pop(32'(dead));
      expect_val("rst_head_x", 32'd40);  check_pop(32'(head_x));
      expect_val("rst_head_y", 32'd30);  check_pop(32'(head_y));
      pixel(320, 240, 12'hF80, "head_px");
      pixel(0, 0, 12'h040, "bg_px_dead_segs");
      pixel(37 * 8 + 5, 30 * 8 + 7, 12'hFF0, "tail_px");

      // Wrap right 79->0, then up 0->59
      for (int i = 0; i < 40; i++) tick(2'b01, 1'b0);
      expect_val("wrap_x", 32'd0);       check_pop(32'(head_x));
      expect_val("wrap_x_y", 32'd30);    check_pop(32'(head_y));
      for (int i = 0; i < 30; i++) tick(2'b00, 1'b0);
      expect_val("up_to_y0", 32'd0);     check_pop(32'(head_y));
      tick(2'b00, 1'b0);
      expect_val("wrap_y", 32'd59);      check_pop(32'(head_y));
      expect_val("wrap_y_x", 32'd0);     check_pop(32'(head_x));

      // Reversal ignored; pending grow applies on the next tick only
      do_reset();
      tick(2'b11, 1'b0);
      expect_val("reverse_x", 32'd41);   check_pop(32'(head_x));
      expect_val("reverse_y", 32'd30);   check_pop(32'(head_y));
      @(negedge clk); grow = 1'b1;
      @(negedge clk); grow = 1'b0;
      expect_val("grow_pending_len", 32'd4); check_pop(32'(length));
      tick(2'b01, 1'b0);
      expect_val("grow_applied_len", 32'd5); check_pop(32'(length));
      tick(2'b01, 1'b0);
      expect_val("grow_cleared_len", 32'd5); check_pop(32'(length));

      // Grow with tick, then saturation
      do_reset();
      tick(2'b01, 1'b1);
      expect_val("grow_tick_len", 32'd5); check_pop(32'(length));
      pixel(37 * 8, 30 * 8, 12'hFF0, "old_tail_body");
      for (int i = 0; i < 20; i++) tick(2'b01, 1'b1);
      expect_val("len_saturate", 32'd16); check_pop(32'(length));
      expect_val("len_sat_head_x", 32'd61); check_pop(32'(head_x));

      // Self-collision
      do_reset();
      tick(2'b00, 1'b1);
      tick(2'b11, 1'b0);
      expect_val("pre_dead", 32'd0);     check_pop(32'(dead));
      tick(2'b10, 1'b0);
      expect_val("dead_set", 32'd1);     check_pop(32'(dead));
      expect_val("dead_head_x", 32'd39); check_pop(32'(head_x));
      expect_val("dead_head_y", 32'd29); check_pop(32'(head_y));
      pixel(39 * 8, 29 * 8, 12'hFFF, "dead_head_px");
      tick(2'b11, 1'b1);
      tick(2'b11, 1'b0);
      expect_val("dead_still_x", 32'd39); check_pop(32'(head_x));
      expect_val("dead_still_len", 32'd5); check_pop(32'(length));
      expect_val("dead_sticky", 32'd1);  check_pop(32'(dead));

      // Target rendering and priority
      do_reset();
      target_x = 7'd10; target_y = 6'd10;
      pixel(85, 83, 12'hF00, "target_px");
      target_x = 7'd39; target_y = 6'd30;
      pixel(39 * 8, 30 * 8, 12'hFF0, "body_over_target");
      target_x = 7'd40;
      pixel(40 * 8, 30 * 8, 12'hF80, "head_over_target");

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/snake_renderer.md
SNAKE_RENDERER -- requirements
Module: snake_renderer

Interface
REQ-001 Parameter MAX_LEN, default 16: maximum snake length in segments (range 4..32).
REQ-002 Parameter GRID_W, default 80: grid width in cells (640 px / 8).
REQ-003 Parameter GRID_H, default 60: grid height in cells (480 px / 8).
REQ-004 CLK  in  1: 25 MHz pixel clock, the same clock that drives the VGA timing stage.
REQ-005 RESET  in  1: one clock; reset is asynchronous and active-low.
REQ-006 ADDR  in  19: pixel address from the VGA stage; ADDR[18:9] = x (0..639), ADDR[8:0] = y (0..479).
REQ-007 MOVE_TICK  in  1: one-cycle pulse; advances the snake one cell.
REQ-008 DIR  in  2: requested direction; 00 up, 01 right, 10 down, 11 left.
REQ-009 GROW  in  1: one-cycle pulse; length +1 at next move.
REQ-010 TARGET_X  in  7 / TARGET_Y  in  6: target cell coordinates.
REQ-011 COLOUR  out  12: registered pixel colour, drives the VGA stage COLOUR_IN.
REQ-012 HEAD_X  out  7 / HEAD_Y  out  6: current head cell.
REQ-013 LENGTH  out  6: current segment count.
REQ-014 DEAD  out  1: sticky self-collision flag.

Function
REQ-015 Cell of current pixel SHALL be cx = ADDR[18:12], cy = ADDR[8:3].
REQ-016 Segment store SHALL be MAX_LEN registered (x,y) pairs; seg[0] is the head, and only seg[0..LENGTH-1] are live.
REQ-017 Current direction SHALL update from DIR only on a MOVE_TICK cycle; a DIR exactly opposite the current direction SHALL be ignored.
REQ-018 On MOVE_TICK with DEAD=0: seg[i] <= seg[i-1] for i = 1..MAX_LEN-1; seg[0] <= next head one cell in the effective direction.
REQ-019 Wrap-around: x 79 -> 0 when moving right, 0 -> 79 when moving left; y 59 -> 0 when moving down, 0 -> 59 when moving up.
REQ-020 GROW SHALL set a pending flag; on the next MOVE_TICK, LENGTH increments (saturates at MAX_LEN) and the flag clears.
REQ-021 GROW coincident with MOVE_TICK SHALL apply to that same move.
REQ-022 Collision: if next head equals any old seg[i], i = 0..LENGTH-2, DEAD SHALL set on that tick, and segments, LENGTH and direction SHALL NOT update.
REQ-023 While DEAD=1, MOVE_TICK and GROW SHALL be ignored; DEAD clears only on reset.
REQ-024 COLOUR SHALL be registered with 1-cycle latency from ADDR.
REQ-025 Colour priority: head cell -> HEAD_COL (DEAD_COL if DEAD); live body cell -> BODY_COL; target cell -> TARGET_COL; otherwise BG_COL.
REQ-026 Colour values: BG_COL 12'h040, BODY_COL 12'hFF0, HEAD_COL 12'hF80, TARGET_COL 12'hF00, DEAD_COL 12'hFFF.
REQ-027 HEAD_X/HEAD_Y SHALL equal seg[0] combinationally from registers (no extra latency).

Reset
REQ-028 While RESET=0: COLOUR=0, DEAD=0, LENGTH=4, direction right, grow flag 0.
REQ-029 Reset segments: seg[0]=(40,30), seg[1]=(39,30), seg[2]=(38,30), seg[3]=(37,30), all others (0,0).
REQ-030 Reset asserted mid-move or mid-frame SHALL take effect immediately (asynchronous) with no partial shift retained.

Structure
REQ-031 Package snake_pkg SHALL hold grid dimensions, cell shift (3), direction encodings, start position, start length and the five colour constants.
REQ-032 Next-head computation with wrap SHALL be a sub-module snake_step (inputs head, dir; output next head); the segment store and compare array stay in snake_renderer.

Verification
REQ-033 Reset, then ADDR x=320,y=240 -> after 1 clk COLOUR=12'hF80; x=0,y=0 -> COLOUR=12'h040; LENGTH=4, HEAD=(40,30).
REQ-034 DIR=right, 40 MOVE_TICKs -> HEAD=(0,30) (wrap from 79); DIR=up from y=0 -> HEAD_Y=59.
REQ-035 Moving right, DIR=left + MOVE_TICK -> HEAD_X increments by 1 (reversal ignored).
REQ-036 GROW and MOVE_TICK in the same cycle -> LENGTH=5, old tail (37,30) still rendered BODY_COL; 20 further GROW+ticks -> LENGTH=16.
REQ-037 From reset: GROW+tick DIR=up, tick DIR=left, tick DIR=down -> DEAD=1 on the third tick, HEAD stays (39,29), head pixel COLOUR=12'hFFF, further ticks change nothing.
REQ-038 TARGET=(10,10), ADDR x=85,y=83 -> COLOUR=12'hF00 after 1 clk; TARGET set to a body cell -> BODY_COL wins.
